// File: rtl/gp_reg.sv
// General-purpose register file: 8 x DATA_W registers, two combinational read
// ports and one opcode-controlled synchronous write port.
module gp_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] SelX,
  input  logic [ADDR_W-1:0] SelY,
  input  logic [ADDR_W-1:0] SelZ,
  input  logic [1:0]        MemInstruction,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_MOVE  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  logic [DATA_W-1:0] regFile_r [NREG];
  logic [DATA_W-1:0] moveSrc_s;
  logic [DATA_W-1:0] wrData_s;
  logic              wrEn_s;

  // Every opcode except NOP writes exactly one register.
  function automatic logic isWrite(input logic [1:0] op);
    logic result;
    case (op)
      OP_MOVE:  result = 1'b1;
      OP_CLEAR: result = 1'b1;
      OP_LOAD:  result = 1'b1;
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic [DATA_W-1:0] writeData(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] moveWord,
    input logic [DATA_W-1:0] memWord
  );
    logic [DATA_W-1:0] result;
    case (op)
      OP_MOVE: result = moveWord;
      OP_LOAD: result = memWord;
      default: result = '0;
    endcase
    return result;
  endfunction

  // MOVE source is the pre-edge content of the register at SelX.
  assign moveSrc_s = regFile_r[SelX];

  // Decode the opcode into a write enable and the data to be written.
  always_comb begin
    wrEn_s   = 1'b0;
    wrData_s = '0;
    if (isWrite(MemInstruction)) begin
      wrEn_s   = 1'b1;
      wrData_s = writeData(MemInstruction, moveSrc_s, MemData);
    end else begin
      wrEn_s   = 1'b0;
      wrData_s = '0;
    end
  end

  // Register array: asynchronous clear has priority over any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_r[i] <= '0;
      end
    end else if (wrEn_s) begin
      regFile_r[SelZ] <= wrData_s;
    end
  end

  // Read ports have no bypass: a write shows up only after its edge.
  assign A = regFile_r[SelX];
  assign B = regFile_r[SelY];

endmodule

// File: tb/tb_gp_reg.sv
// Self-checking bench for gp_reg: expected values go into a scoreboard queue
// when stimulus is applied and are popped when the outputs are sampled.
module tb_gp_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  SelX, SelY, SelZ;
  logic [1:0]  MemInstruction;
  logic [31:0] MemData;
  logic [31:0] A, B;

  int          passCount  = 0;
  int          checkCount = 0;
  logic [31:0] expQ[$];
  logic [31:0] model[8];

  gp_reg #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .SelX(SelX), .SelY(SelY), .SelZ(SelZ),
    .MemInstruction(MemInstruction), .MemData(MemData), .A(A), .B(B)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelWrite(input logic [1:0] op, input logic [2:0] x, input logic [2:0] z,
                            input logic [31:0] d);
    case (op)
      2'b01:   model[z] = model[x];
      2'b10:   model[z] = 32'h0;
      2'b11:   model[z] = d;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_n = 1'b0;
    MemInstruction = 2'b00;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      SelX = i[2:0];
      SelY = 3'(7 - i);
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
      #1;
      e = expQ.pop_front(); checkCount++;
      if (A !== e) $display("FAIL reset_A[%0d]: A=%h expected %h", i, A, e); else passCount++;
      e = expQ.pop_front(); checkCount++;
      if (B !== e) $display("FAIL reset_B[%0d]: B=%h expected %h", i, B, e); else passCount++;
    end
  endtask

  task automatic test_load();
    logic [31:0] e;
    logic [2:0]  zs[3];
    logic [31:0] ds[3];
    zs = '{3'd0, 3'd1, 3'd2};
    ds = '{32'd55, 32'd44, 32'd37};
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      MemInstruction = 2'b11;
      SelZ = zs[k];
      SelX = zs[k];
      MemData = ds[k];
      expQ.push_back(32'h0);
      #1;
      e = expQ.pop_front(); checkCount++;
      if (A !== e) $display("FAIL load_pre[%0d]: A=%h expected %h", k, A, e); else passCount++;
      step();
      expQ.push_back(ds[k]);
      #1;
      e = expQ.pop_front(); checkCount++;
      if (A !== e) $display("FAIL load_post[%0d]: A=%h expected %h", k, A, e); else passCount++;
      modelWrite(2'b11, 3'd0, zs[k], ds[k]);
    end
    MemInstruction = 2'b00;
    SelX = 3'd0; SelY = 3'd2;
    expQ.push_back(32'd55); expQ.push_back(32'd37);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL load_r0: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL load_r2: B=%h expected %h", B, e); else passCount++;
    SelX = 3'd1;
    expQ.push_back(32'd44);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL load_r1: A=%h expected %h", A, e); else passCount++;
  endtask

  task automatic test_dual_read_nop();
    logic [31:0] e;
    SelX = 3'd1; SelY = 3'd2; SelZ = 3'd1;
    MemInstruction = 2'b00; MemData = 32'd55;
    expQ.push_back(32'd44); expQ.push_back(32'd37);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL nop_pre_A: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL nop_pre_B: B=%h expected %h", B, e); else passCount++;
    step();
    expQ.push_back(32'd44);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL nop_r1_hold: A=%h expected %h", A, e); else passCount++;
    SelX = 3'd0;
    expQ.push_back(32'd55);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL nop_r0_hold: A=%h expected %h", A, e); else passCount++;
  endtask

  task automatic test_move();
    logic [31:0] e;
    MemInstruction = 2'b01; SelX = 3'd1; SelY = 3'd2; SelZ = 3'd0;
    expQ.push_back(32'd44); expQ.push_back(32'd37);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL move_pre_A: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL move_pre_B: B=%h expected %h", B, e); else passCount++;
    step();
    modelWrite(2'b01, 3'd1, 3'd0, 32'h0);
    MemInstruction = 2'b00;
    SelX = 3'd0;
    expQ.push_back(32'd44); expQ.push_back(32'd37);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL move_r0: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL move_r2_hold: B=%h expected %h", B, e); else passCount++;
    SelX = 3'd1;
    expQ.push_back(32'd44);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL move_r1_hold: A=%h expected %h", A, e); else passCount++;
    MemInstruction = 2'b01; SelX = 3'd2; SelZ = 3'd2; SelY = 3'd2;
    step();
    MemInstruction = 2'b00;
    expQ.push_back(32'd37);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL move_self: B=%h expected %h", B, e); else passCount++;
  endtask

  task automatic test_clear_same_reg();
    logic [31:0] e;
    logic [31:0] exp8[8];
    exp8 = '{32'd44, 32'd44, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    MemInstruction = 2'b10; SelZ = 3'd2; SelX = 3'd2; SelY = 3'd2;
    expQ.push_back(32'd37); expQ.push_back(32'd37);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL clear_pre_A: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL clear_pre_B: B=%h expected %h", B, e); else passCount++;
    step();
    modelWrite(2'b10, 3'd0, 3'd2, 32'h0);
    expQ.push_back(32'd0); expQ.push_back(32'd0);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL clear_post_A: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL clear_post_B: B=%h expected %h", B, e); else passCount++;
    MemInstruction = 2'b11; SelZ = 3'd7; SelX = 3'd7; MemData = 32'hFFFF_FFFF;
    step();
    modelWrite(2'b11, 3'd0, 3'd7, 32'hFFFF_FFFF);
    MemInstruction = 2'b00;
    expQ.push_back(32'hFFFF_FFFF);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL load_r7: A=%h expected %h", A, e); else passCount++;
    for (int i = 0; i < 8; i++) begin
      SelX = i[2:0];
      SelY = i[2:0];
      expQ.push_back(exp8[i]); expQ.push_back(exp8[i]);
      #1;
      e = expQ.pop_front(); checkCount++;
      if (A !== e) $display("FAIL sweep_A[%0d]: A=%h expected %h", i, A, e); else passCount++;
      e = expQ.pop_front(); checkCount++;
      if (B !== e) $display("FAIL sweep_B[%0d]: B=%h expected %h", i, B, e); else passCount++;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    MemInstruction = 2'b00; SelX = 3'd7; SelY = 3'd0;
    #1;
    rst_n = 1'b0;
    MemInstruction = 2'b11; SelZ = 3'd3; MemData = 32'h0000_0ABC;
    expQ.push_back(32'h0); expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL async_rst_A: A=%h expected %h", A, e); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (B !== e) $display("FAIL async_rst_B: B=%h expected %h", B, e); else passCount++;
    step();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    SelX = 3'd3;
    expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL rst_priority: A=%h expected %h", A, e); else passCount++;
    rst_n = 1'b1;
    MemData = 32'h1234_5678;
    step();
    modelWrite(2'b11, 3'd0, 3'd3, 32'h1234_5678);
    MemInstruction = 2'b00;
    expQ.push_back(32'h1234_5678);
    #1;
    e = expQ.pop_front(); checkCount++;
    if (A !== e) $display("FAIL first_write: A=%h expected %h", A, e); else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [1:0]  op;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      MemInstruction = op;
      SelX = 3'($urandom_range(0, 7));
      SelY = 3'($urandom_range(0, 7));
      SelZ = 3'($urandom_range(0, 7));
      MemData = $urandom;
      expQ.push_back(model[SelX]); expQ.push_back(model[SelY]);
      #1;
      e = expQ.pop_front(); checkCount++;
      if (A !== e) $display("FAIL b2b_A[%0d]: A=%h expected %h", n, A, e); else passCount++;
      e = expQ.pop_front(); checkCount++;
      if (B !== e) $display("FAIL b2b_B[%0d]: B=%h expected %h", n, B, e); else passCount++;
      modelWrite(op, SelX, SelZ, MemData);
      step();
    end
    MemInstruction = 2'b00;
    for (int i = 0; i < 8; i++) begin
      SelX = i[2:0];
      expQ.push_back(model[i]);
      #1;
      e = expQ.pop_front(); checkCount++;
      if (A !== e) $display("FAIL b2b_final[%0d]: A=%h expected %h", i, A, e); else passCount++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    SelX = 3'd0; SelY = 3'd0; SelZ = 3'd0;
    MemInstruction = 2'b00;
    MemData = 32'h0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    test_reset();
    test_load();
    test_dual_read_nop();
    test_move();
    test_clear_same_reg();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
